vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Sits between vga_sync and a single-port synchronous frame-buffer RAM (1-cycle read latency).
- Shares the RAM port between two requesters:
  - the display fetch, which has absolute priority whenever video_on=1;
  - one writer (drawing engine or host), which is serviced only during blanking through a req/ack handshake.
- Produces pixel colour and sync outputs that are delay-matched to each other for the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- DATA_W, 3, pixel data width (RGB).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- p_tick  in  1  pixel-rate enable from vga_sync.
- video_on  in  1  from vga_sync.
- pixel_y  in  10  current line from vga_sync.
- hsync_in  in  1  from vga_sync.
- vsync_in  in  1  from vga_sync.
- wr_req  in  1  writer request; held until acknowledged.
- wr_addr  in  ADDR_W  writer address; stable while wr_req=1.
- wr_data  in  DATA_W  writer data; stable while wr_req=1.
- wr_ack  out  1  single-cycle acknowledge; the write occurs in this cycle.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid one clk after mem_addr.
- rgb  out  DATA_W  pixel colour to DAC pins.
- hsync  out  1  hsync_in delayed 2 clk.
- vsync  out  1  vsync_in delayed 2 clk.
- frame_start  out  1  one-clk pulse on disp_addr reset.

Behaviour:

Reset (rst=0, asynchronous):
- All registers clear: disp_addr=0, state=IDLE, rgb=0, hsync=0, vsync=0, frame_start=0, delay pipes=0.
- Combinational outputs evaluate accordingly: wr_ack=0, mem_we=0, mem_addr=0.

Display address counter (disp_addr, ADDR_W bits, registered):
- Increments by 1 on clk when p_tick=1 and video_on=1.
- Loads 0 when video_on=0 and pixel_y==V_ACTIVE.
  - frame_start pulses for the first clk of that load condition only; it is edge-detected, not level.
- Never exceeds H_ACTIVE*V_ACTIVE; no wrap is needed within a frame.

Port grant (combinational mux):
- grant = (state==IDLE) & ~video_on & wr_req.
- grant=1:
  - mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1, wr_ack=1.
- Otherwise:
  - mem_addr=disp_addr, mem_we=0, wr_ack=0, mem_wdata=0.
- video_on=1 always blocks grant. The display is never starved, so no display read is ever lost.

Writer state machine:
- IDLE -> HOLD when grant=1.
- HOLD -> IDLE unconditionally on the next clk. This gives one dead cycle so the writer can drop or change wr_req.
- Maximum write throughput is therefore one write per 2 clk during blanking.
- wr_req arriving during active video waits, with no timeout, until video_on=0.
- The writer must not change wr_addr or wr_data while wr_req=1 and wr_ack=0.

Pixel output pipeline:
- von_d1 is video_on delayed 1 clk.
- rgb is registered: rgb <= von_d1 ? mem_rdata : 0.
- A grant cycle always has video_on=0, so the following cycle has von_d1=0 and rgb=0. Written data never appears on rgb.
- hsync and vsync each pass through a 2-stage register pipe, so rgb, hsync and vsync stay aligned (2 clk after the vga_sync outputs).

Simultaneous events:
- The load-to-0 condition and the increment condition are mutually exclusive, because they require opposite video_on values.
- grant and the disp_addr reset may occur in the same clk; both take effect.

Reset mid-write:
- state goes to IDLE; wr_ack drops immediately because it is combinational on state and inputs.
- The writer re-requests after rst deasserts.

Test Plan:
1. Reset: rst=0 with wr_req=1, video_on=0 -> wr_ack=0, mem_we=0, rgb=0, disp_addr=0. After rst=1 -> wr_ack=1 on the first clk.
2. Display fetch: video_on=1 with p_tick every 4 clk for 640 ticks -> mem_addr steps 0..639 with mem_we=0 throughout. With RAM preloaded with addr[2:0], rgb shows that pattern 2 clk later, and hsync/vsync are delayed by the same 2 clk.
3. Write blocked then granted: wr_req=1, wr_addr=0x00123, wr_data=3'b101 asserted mid-line with video_on=1 -> no ack. On the first clk after video_on=0 -> wr_ack=1 and mem_we=1 for exactly 1 clk, and RAM[0x123]=5.
4. Back-to-back writes: wr_req held high with a new address and data after each ack, during blanking -> acks exactly every 2 clk with no gap violations, and rgb=0 throughout.
5. Frame wrap: run to pixel_y=480 with video_on=0 -> disp_addr=0 and a single 1-clk frame_start. The next frame's first fetch uses mem_addr=0.
6. Async reset mid-line: rst pulsed low for 3 ns at disp_addr=200 -> outputs clear without waiting for a clk edge. disp_addr restarts at 0 and counts correctly after release.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Shares one single-port synchronous frame-buffer RAM
//               (1-cycle read latency) between the display fetch and a
//               single writer. The display owns the port whenever video_on
//               is high. The writer is served only during blanking, through
//               a req/ack handshake, and then waits one dead cycle after
//               each write. Drives pixel colour and the sync signals with
//               matched 2-clk latency.
// Ports       : clk, rst (async, active-low)
//               p_tick, video_on, pixel_y, hsync_in, vsync_in : from vga_sync
//               wr_req/wr_addr/wr_data -> wr_ack             : writer handshake
//               mem_addr/mem_we/mem_wdata, mem_rdata         : RAM port
//               rgb, hsync, vsync                            : VGA pins
//               frame_start                                  : display address wrap
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_y,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] c_frame_px  = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [9:0]        c_last_line = 10'(V_ACTIVE);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_hold = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              grant;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic              frame_load;
  logic              load_prev_q;
  logic              frame_start_q;
  logic              von_d1_q;
  logic [DATA_W-1:0] rgb_q;
  logic [1:0]        hs_pipe_q;
  logic [1:0]        vs_pipe_q;

  // First line below the visible area: display address returns to 0.
  assign frame_load = ~video_on & (pixel_y == c_last_line);

  // --------------------------------------------------------------------------
  // Writer FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Writer FSM: next state. HOLD is the single dead cycle after a write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (grant) state_d = c_st_hold;
      c_st_hold: state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  // Writer FSM: outputs / port mux. rst is folded in so the handshake
  // drops immediately on reset, without waiting for a clock edge.
  always_comb begin
    grant     = rst & (state_q == c_st_idle) & ~video_on & wr_req;
    wr_ack    = grant;
    mem_we    = grant;
    mem_addr  = grant ? wr_addr : disp_addr_q;
    mem_wdata = grant ? wr_data : '0;
  end

  // --------------------------------------------------------------------------
  // Display address counter. The increment and the frame load need opposite
  // video_on values, so they can never collide. The counter holds at the
  // frame size as a guard against a malformed sync stream.
  // --------------------------------------------------------------------------
  always_comb begin
    disp_addr_d = disp_addr_q;
    if (video_on & p_tick) begin
      if (disp_addr_q != c_frame_px) disp_addr_d = disp_addr_q + ADDR_W'(1);
    end else if (frame_load) begin
      disp_addr_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers: address counter, frame_start edge detect, pixel pipe
  // and 2-stage sync pipes (rgb is 2 clk behind vga_sync: RAM + output reg).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_addr_q   <= '0;
      load_prev_q   <= 1'b0;
      frame_start_q <= 1'b0;
      von_d1_q      <= 1'b0;
      rgb_q         <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
    end else begin
      disp_addr_q   <= disp_addr_d;
      load_prev_q   <= frame_load;
      frame_start_q <= frame_load & ~load_prev_q;
      von_d1_q      <= video_on;
      // Blank whenever the read was not a display fetch; write data never
      // leaks to the pins because grants only happen with video_on low.
      rgb_q         <= von_d1_q ? mem_rdata : '0;
      hs_pipe_q     <= {hs_pipe_q[0], hsync_in};
      vs_pipe_q     <= {vs_pipe_q[0], vsync_in};
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hs_pipe_q[1];
  assign vsync       = vs_pipe_q[1];
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_arbiter
// Description : Self-checking bench for vga_fb_arbiter. A behavioural model
//               tracks pixels fetched per frame, cycles since the last write,
//               and per-cycle histories of display data and syncs. It is
//               compared with the DUT every cycle. Directed literal checks
//               pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

  localparam int AW = 19;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p_tick = 1'b0;
  logic          video_on = 1'b0;
  logic [9:0]    pixel_y = '0;
  logic          hsync_in = 1'b0;
  logic          vsync_in = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] rgb;
  logic          hsync;
  logic          vsync;
  logic          frame_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs_cnt = 0;
  bit chk_en = 1'b0;

  vga_fb_arbiter #(
    .H_ACTIVE(640), .V_ACTIVE(480), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .p_tick(p_tick), .video_on(video_on),
    .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rgb(rgb), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-buffer RAM attached to the DUT: synchronous, 1-cycle read latency.
  logic [DW-1:0] ram   [0:(1<<AW)-1];
  // Model's own view of the frame-buffer contents.
  logic [DW-1:0] ram_m [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int      m_pix;          // pixels fetched since the start of this frame
  int      m_since_ack;    // cycles since the last writer acknowledge
  int      m_run480;       // consecutive blanking cycles on the line below the frame
  logic [DW-1:0] m_px_q[$];   // display data seen per cycle, newest first
  bit      m_hs_q[$];
  bit      m_vs_q[$];

  function automatic bit m_grant();
    return rst && (m_since_ack >= 2) && !video_on && wr_req;
  endfunction

  function automatic bit m_wrap_line();
    return !video_on && (pixel_y == 10'd480);
  endfunction

  initial begin
    m_pix = 0; m_since_ack = 2; m_run480 = 0;
    m_px_q = '{3'd0, 3'd0}; m_hs_q = '{1'b0, 1'b0}; m_vs_q = '{1'b0, 1'b0};
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pix = 0; m_since_ack = 2; m_run480 = 0;
      m_px_q = '{3'd0, 3'd0}; m_hs_q = '{1'b0, 1'b0}; m_vs_q = '{1'b0, 1'b0};
    end else begin
      // Pixel shown two cycles from now: the display word if video is on.
      m_px_q.push_front(video_on ? ram_m[m_pix] : 3'd0);
      void'(m_px_q.pop_back());
      m_hs_q.push_front(hsync_in); void'(m_hs_q.pop_back());
      m_vs_q.push_front(vsync_in); void'(m_vs_q.pop_back());
      if (m_grant()) begin
        ram_m[wr_addr] = wr_data;
        m_since_ack = 1;
      end else if (m_since_ack < 100) begin
        m_since_ack = m_since_ack + 1;
      end
      if (video_on && p_tick) m_pix = m_pix + 1;
      else if (m_wrap_line()) m_pix = 0;
      m_run480 = m_wrap_line() ? ((m_run480 < 1000) ? m_run480 + 1 : m_run480) : 0;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin : cmp
    bit g;
    if (chk_en) begin
      g = m_grant();
      check("wr_ack",      32'(wr_ack),      32'(g));
      check("mem_we",      32'(mem_we),      32'(g));
      check("mem_addr",    32'(mem_addr),    g ? 32'(wr_addr) : 32'(m_pix));
      check("mem_wdata",   32'(mem_wdata),   g ? 32'(wr_data) : 32'd0);
      check("rgb",         32'(rgb),         32'(m_px_q[1]));
      check("hsync",       32'(hsync),       32'(m_hs_q[1]));
      check("vsync",       32'(vsync),       32'(m_vs_q[1]));
      check("frame_start", 32'(frame_start), 32'(m_run480 == 1));
    end
    if (frame_start === 1'b1) fs_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  initial begin : stim
    int last_ack;
    int n_acks;
    int fs_before;
    bit got;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = i[2:0];
      ram_m[i] = i[2:0];
    end

    // 1. Reset with a pending write request during blanking.
    #1;
    rst = 1'b0;
    wr_req = 1'b1; wr_addr = 19'h00010; wr_data = 3'd2; video_on = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    #1;
    check("rst_wr_ack",   32'(wr_ack),   32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_rgb",      32'(rgb),      32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b1;
    #1;
    check("ack_after_rst",      32'(wr_ack),   32'd1);
    check("ack_after_rst_addr", 32'(mem_addr), 32'h10);
    tick();
    wr_req = 1'b0;
    tick();

    // 2. One line of display fetch, p_tick every 4 clk.
    pixel_y = 10'd0;
    for (int i = 0; i < 640; i++) begin
      video_on = 1'b1; p_tick = 1'b1;
      hsync_in = (i % 7 == 0); vsync_in = (i % 5 == 0);
      if (i == 100) begin #1; check("fetch_addr_100", 32'(mem_addr), 32'd100); end
      if (i == 98)  begin #1; check("hsync_before_98", 32'(hsync), 32'd0); end
      tick();
      p_tick = 1'b0;
      tick();
      if (i == 100) begin #1; check("rgb_px100", 32'(rgb), 32'd4); end
      if (i == 98)  begin #1; check("hsync_delay_98", 32'(hsync), 32'd1); end
      tick(); tick();
    end
    video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    #1;
    check("fetch_count", 32'(mem_addr), 32'd640);
    tick(); tick(); tick();

    // 3. Write request during active video waits for blanking.
    pixel_y = 10'd1;
    for (int i = 0; i < 10; i++) begin
      video_on = 1'b1; p_tick = 1'b1;
      if (i == 3) begin wr_req = 1'b1; wr_addr = 19'h00123; wr_data = 3'b101; end
      tick();
      p_tick = 1'b0;
      #1;
      if (i >= 3) check("blocked_ack", 32'(wr_ack), 32'd0);
      tick(); tick(); tick();
    end
    video_on = 1'b0;
    #1;
    check("grant_ack",  32'(wr_ack),   32'd1);
    check("grant_we",   32'(mem_we),   32'd1);
    check("grant_addr", 32'(mem_addr), 32'h123);
    tick();
    wr_req = 1'b0;
    #1;
    check("ack_single", 32'(wr_ack), 32'd0);
    tick(); tick();
    check("ram_0x123", 32'(ram[19'h123]), 32'd5);

    // 4. Back-to-back writes during blanking.
    last_ack = -1; n_acks = 0;
    for (int k = 0; k < 6; k++) begin
      wr_req = 1'b1; wr_addr = 19'h00200 + 19'(k); wr_data = 3'(k + 1);
      got = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
        #1;
        if (wr_ack) begin
          got = 1'b1;
          n_acks++;
          if (last_ack >= 0) check("ack_spacing", 32'(cyc - last_ack), 32'd2);
          last_ack = cyc;
          check("b2b_rgb", 32'(rgb), 32'd0);
        end
        tick();
      end
      if (!got) check("ack_timeout", 32'd0, 32'd1);
    end
    wr_req = 1'b0;
    tick(); tick();
    check("b2b_acks",  32'(n_acks),         32'd6);
    check("ram_0x205", 32'(ram[19'h205]),   32'd6);

    // 5. Frame wrap, with a write granted in the same cycle as the reload.
    fs_before = fs_cnt;
    pixel_y = 10'd480; video_on = 1'b0;
    wr_req = 1'b1; wr_addr = 19'h00300; wr_data = 3'd6;
    #1;
    check("wrap_grant_addr", 32'(mem_addr), 32'h300);
    tick();
    wr_req = 1'b0;
    #1;
    check("wrap_addr",        32'(mem_addr),    32'd0);
    check("wrap_frame_start", 32'(frame_start), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("frame_start_pulses", 32'(fs_cnt - fs_before), 32'd1);
    check("ram_0x300", 32'(ram[19'h300]), 32'd6);
    pixel_y = 10'd0;

    // 6. Async reset mid-line with disp_addr at 200.
    for (int i = 0; i < 199; i++) begin
      video_on = 1'b1; p_tick = 1'b1; hsync_in = 1'b1;
      if (i == 0) begin #1; check("first_fetch", 32'(mem_addr), 32'd0); end
      tick();
      p_tick = 1'b0;
      tick(); tick(); tick();
    end
    p_tick = 1'b1;
    tick();
    p_tick = 1'b0;
    check("pre_rst_addr",  32'(mem_addr), 32'd200);
    check("pre_rst_rgb",   32'(rgb),      32'd7);
    check("pre_rst_hsync", 32'(hsync),    32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_rgb",   32'(rgb),      32'd0);
    check("async_addr",  32'(mem_addr), 32'd0);
    check("async_hsync", 32'(hsync),    32'd0);
    #2 rst = 1'b1;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      video_on = 1'b1; p_tick = 1'b1;
      tick();
      p_tick = 1'b0;
      tick(); tick(); tick();
    end
    check("restart_count", 32'(mem_addr), 32'd10);
    video_on = 1'b0; hsync_in = 1'b0;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
